// File: rtl/nibble_serial_adder.sv
// Nibble-serial adder: one 4-bit carry-lookahead slice per cycle, valid/ready on both sides.
// Define SIGNED_OVF_EN to add the signed-overflow output ovf.
module nibble_serial_adder #(
    parameter int unsigned NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [4*NIBBLES-1:0] a,
    input  logic [4*NIBBLES-1:0] b,
    input  logic                 cin,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [4*NIBBLES-1:0] sum,
    output logic                 cout
`ifdef SIGNED_OVF_EN
    ,
    output logic                 ovf
`endif
);

    localparam int unsigned W  = 4 * NIBBLES;
    localparam int unsigned KW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    typedef enum logic [1:0] {StIdle, StAdd, StDone} state_e;

    state_e         state_q, state_d;
    logic [W-1:0]   a_q, a_d;
    logic [W-1:0]   b_q, b_d;
    logic [W-1:0]   sum_q, sum_d;
    logic [KW-1:0]  k_q, k_d;
    logic           carry_q, carry_d;
    logic           cout_q, cout_d;
`ifdef SIGNED_OVF_EN
    logic           ovf_q, ovf_d;
`endif

    logic [3:0] nib_a, nib_b, nib_p, nib_g, nib_s;
    logic [4:0] c;
    logic       last_nib;

    // Select the active nibble of the captured operands.
    always_comb begin
        nib_a = '0;
        nib_b = '0;
        for (int unsigned i = 0; i < NIBBLES; i++) begin
            if (k_q == KW'(i)) begin
                nib_a = a_q[4*i +: 4];
                nib_b = b_q[4*i +: 4];
            end
        end
    end

    // Two-level lookahead: every carry is a flat sum of products of G, P and c[0].
    always_comb begin
        nib_p = nib_a ^ nib_b;
        nib_g = nib_a & nib_b;
        c[0]  = carry_q;
        c[1]  = nib_g[0] | (nib_p[0] & c[0]);
        c[2]  = nib_g[1] | (nib_p[1] & nib_g[0]) | (nib_p[1] & nib_p[0] & c[0]);
        c[3]  = nib_g[2] | (nib_p[2] & nib_g[1]) | (nib_p[2] & nib_p[1] & nib_g[0])
              | (nib_p[2] & nib_p[1] & nib_p[0] & c[0]);
        c[4]  = nib_g[3] | (nib_p[3] & nib_g[2]) | (nib_p[3] & nib_p[2] & nib_g[1])
              | (nib_p[3] & nib_p[2] & nib_p[1] & nib_g[0])
              | (nib_p[3] & nib_p[2] & nib_p[1] & nib_p[0] & c[0]);
        nib_s = nib_p ^ c[3:0];
    end

    assign last_nib = (k_q == KW'(NIBBLES - 1));

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        k_d     = k_q;
        carry_d = carry_q;
        cout_d  = cout_q;
`ifdef SIGNED_OVF_EN
        ovf_d   = ovf_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    k_d     = '0;
                    state_d = StAdd;
                end
            end
            StAdd: begin
                for (int unsigned i = 0; i < NIBBLES; i++) begin
                    if (k_q == KW'(i)) begin
                        sum_d[4*i +: 4] = nib_s;
                    end
                end
                carry_d = c[4];
                k_d     = k_q + 1'b1;
                if (last_nib) begin
                    cout_d  = c[4];
`ifdef SIGNED_OVF_EN
                    ovf_d   = c[3] ^ c[4];
`endif
                    k_d     = '0;
                    state_d = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            k_q     <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
`ifdef SIGNED_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            k_q     <= k_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
`ifdef SIGNED_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign sum       = sum_q;
    assign cout      = cout_q;
`ifdef SIGNED_OVF_EN
    assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Bench for nibble_serial_adder: a NIBBLES=4 instance plus a NIBBLES=1 instance for a full sweep.
module tb_nibble_serial_adder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        in_valid = 1'b0, out_ready = 1'b0, cin = 1'b0;
    logic [15:0] a = '0, b = '0;
    logic        in_ready, out_valid, cout;
    logic [15:0] sum;
    logic        ovf;

    logic        s_in_valid = 1'b0, s_out_ready = 1'b0, s_cin = 1'b0;
    logic [3:0]  s_a = '0, s_b = '0;
    logic        s_in_ready, s_out_valid, s_cout;
    logic [3:0]  s_sum;
    logic        s_ovf;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    nibble_serial_adder #(.NIBBLES(4)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
`ifdef SIGNED_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    nibble_serial_adder #(.NIBBLES(1)) u_dut1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (s_in_valid),
        .in_ready  (s_in_ready),
        .a         (s_a),
        .b         (s_b),
        .cin       (s_cin),
        .out_valid (s_out_valid),
        .out_ready (s_out_ready),
        .sum       (s_sum),
        .cout      (s_cout)
`ifdef SIGNED_OVF_EN
        ,
        .ovf       (s_ovf)
`endif
    );

`ifndef SIGNED_OVF_EN
    assign ovf   = 1'b0;
    assign s_ovf = 1'b0;
`endif

    // Present operands, wait for the accepting edge, then scramble the inputs and count
    // edges until out_valid. Leaves the DUT holding its result in DONE.
    task automatic run_op(input logic [15:0] xa, input logic [15:0] xb, input logic xc,
                          output int lat, output logic [15:0] rs, output logic rc);
        a = xa; b = xb; cin = xc; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
        lat = -1;
        for (int e = 1; e <= 40; e++) begin
            @(posedge clk); #1;
            if (out_valid) begin
                lat = e;
                break;
            end
        end
        in_valid = 1'b0;
        rs = sum;
        rc = cout;
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || sum !== 16'h0 || cout !== 1'b0
            || ovf !== 1'b0) begin
            bad++;
            $display("FAIL reset4: rdy=%b vld=%b sum=%h cout=%b ovf=%b, want 1 0 0000 0 0",
                     in_ready, out_valid, sum, cout, ovf);
        end
        total++;
        if (s_in_ready !== 1'b1 || s_out_valid !== 1'b0 || s_sum !== 4'h0 || s_cout !== 1'b0)
        begin
            bad++;
            $display("FAIL reset1: rdy=%b vld=%b sum=%h cout=%b, want 1 0 0 0",
                     s_in_ready, s_out_valid, s_sum, s_cout);
        end
    endtask

    task automatic test_carry_wrap();
        int lat; logic [15:0] rs; logic rc;
        run_op(16'hFFFF, 16'h0001, 1'b0, lat, rs, rc);
        total++;
        if (lat !== 4) begin
            bad++;
            $display("FAIL wrap_latency: got %0d edges, want 4", lat);
        end
        total++;
        if (rs !== 16'h0000 || rc !== 1'b1) begin
            bad++;
            $display("FAIL wrap_result: got sum=%h cout=%b, want 0000 1", rs, rc);
        end
        release_result();
    endtask

    task automatic test_handshake();
        int lowcnt = 0;
        a = 16'h1234; b = 16'h4321; cin = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int e = 0; e < 4; e++) begin
            if (in_ready === 1'b0) lowcnt++;
            @(posedge clk); #1;
        end
        if (in_ready === 1'b0) lowcnt++;
        total++;
        if (lowcnt !== 5 || out_valid !== 1'b1) begin
            bad++;
            $display("FAIL hs_ready_low: low for %0d sampled cycles, vld=%b, want 5 1",
                     lowcnt, out_valid);
        end
        total++;
        if (sum !== 16'h5556 || cout !== 1'b0) begin
            bad++;
            $display("FAIL hs_result: got sum=%h cout=%b, want 5556 0", sum, cout);
        end
        release_result();
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL hs_release: rdy=%b vld=%b, want 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_backpressure();
        int lat; logic [15:0] rs; logic rc;
        run_op(16'hA5C3, 16'h7E19, 1'b1, lat, rs, rc);
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
            @(posedge clk); #1;
            total++;
            if (sum !== 16'h23DD || cout !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b1)
            begin
                bad++;
                $display("FAIL bp_hold%0d: sum=%h cout=%b rdy=%b vld=%b, want 23dd 1 0 1",
                         i, sum, cout, in_ready, out_valid);
            end
        end
        in_valid = 1'b0;
        release_result();
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL bp_release: rdy=%b vld=%b, want 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_reset_mid_add();
        int lat; logic [15:0] rs; logic rc;
        a = 16'h1357; b = 16'h9BDF; cin = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); @(posedge clk); #2;
        rst = 1'b1;
        #1;
        total++;
        if (sum !== 16'h0 || cout !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL rst_mid_add: sum=%h cout=%b vld=%b rdy=%b, want 0000 0 0 1",
                     sum, cout, out_valid, in_ready);
        end
        #1 rst = 1'b0;
        run_op(16'h0F0F, 16'hF0F1, 1'b0, lat, rs, rc);
        total++;
        if (lat !== 4 || rs !== 16'h0000 || rc !== 1'b1) begin
            bad++;
            $display("FAIL rst_recover: lat=%0d sum=%h cout=%b, want 4 0000 1", lat, rs, rc);
        end
        release_result();
    endtask

`ifdef SIGNED_OVF_EN
    task automatic test_ovf();
        logic [15:0] ta [3] = '{16'h7FFF, 16'h8000, 16'hFFFF};
        logic [15:0] tb [3] = '{16'h0001, 16'h8000, 16'h0001};
        logic [16:0] want [3] = '{17'h08000, 17'h10000, 17'h10000};
        logic        wovf [3] = '{1'b1, 1'b1, 1'b0};
        int lat; logic [15:0] rs; logic rc;
        for (int i = 0; i < 3; i++) begin
            run_op(ta[i], tb[i], 1'b0, lat, rs, rc);
            total++;
            if ({rc, rs} !== want[i] || ovf !== wovf[i]) begin
                bad++;
                $display("FAIL ovf%0d: cout,sum=%h ovf=%b, want %h %b",
                         i, {rc, rs}, ovf, want[i], wovf[i]);
            end
            release_result();
        end
    endtask
`endif

    task automatic test_random();
        int lat; logic [15:0] rs; logic rc;
        logic [15:0] xa, xb; logic xc;
        logic [16:0] full;
        logic        wovf;
        for (int n = 0; n < 60; n++) begin
            xa = 16'($urandom); xb = 16'($urandom); xc = 1'($urandom);
            full = 17'(xa) + 17'(xb) + 17'(xc);
            wovf = (xa[15] == xb[15]) && (full[15] != xa[15]);
            run_op(xa, xb, xc, lat, rs, rc);
            total++;
            if (lat !== 4 || {rc, rs} !== full) begin
                bad++;
                $display("FAIL rand%0d: %h+%h+%b lat=%0d got %h, want lat 4 %h",
                         n, xa, xb, xc, lat, {rc, rs}, full);
            end
`ifdef SIGNED_OVF_EN
            total++;
            if (ovf !== wovf) begin
                bad++;
                $display("FAIL rand_ovf%0d: got %b want %b", n, ovf, wovf);
            end
`endif
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
            release_result();
        end
    endtask

    task automatic test_exhaustive_n1();
        logic [4:0] full;
        logic       wovf;
        for (int va = 0; va < 16; va++) begin
            for (int vb = 0; vb < 16; vb++) begin
                for (int vc = 0; vc < 2; vc++) begin
                    s_a = 4'(va); s_b = 4'(vb); s_cin = 1'(vc); s_in_valid = 1'b1;
                    full = 5'(va) + 5'(vb) + 5'(vc);
                    wovf = (s_a[3] == s_b[3]) && (full[3] != s_a[3]);
                    @(posedge clk); #1;
                    s_in_valid = 1'b0;
                    @(posedge clk); #1;
                    total++;
                    if (s_out_valid !== 1'b1 || {s_cout, s_sum} !== full) begin
                        bad++;
                        $display("FAIL n1 %0d+%0d+%0d: vld=%b got %h, want 1 %h",
                                 va, vb, vc, s_out_valid, {s_cout, s_sum}, full);
                    end
`ifdef SIGNED_OVF_EN
                    total++;
                    if (s_ovf !== wovf) begin
                        bad++;
                        $display("FAIL n1_ovf %0d+%0d+%0d: got %b want %b",
                                 va, vb, vc, s_ovf, wovf);
                    end
`endif
                    s_out_ready = 1'b1;
                    @(posedge clk); #1;
                    s_out_ready = 1'b0;
                end
            end
        end
    endtask

    initial begin
        #12;
        test_reset();
        rst = 1'b0;
        @(posedge clk); #1;
        test_carry_wrap();
        test_handshake();
        test_backpressure();
        test_reset_mid_add();
`ifdef SIGNED_OVF_EN
        test_ovf();
`endif
        test_random();
        test_exhaustive_n1();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
